fighter_action_ctrl: RTL
========================

# fighter_action_ctrl

Per-player action sequencer that drives the sprite renderer's `character_state`, `move_state`, `in_air`, `x` and `y` inputs. It turns debounced button levels and a collision `hit` pulse into timed punch/special/injured sequences, walking and jumping. All game-state updates occur on the shared 8 Hz animation tick, so sprite frame changes stay phase-aligned with state changes. One instance per fighter sits between the input/collision logic and the sprite renderer.

## Interface
- `X_INIT`, 20: x after reset
- `X_MIN` / `X_MAX`, 8 / 88: x clamp bounds, inclusive
- `Y_GROUND`, 32: y when grounded
- `STEP`, 2: pixels moved per tick (walk, knockback, jump)
- `PUNCH_TICKS` / `SP_TICKS` / `INJ_TICKS`, 2 / 4 / 3: state durations in ticks
- `JUMP_TICKS`, 4: ticks of ascent; descent also lasts `JUMP_TICKS`
- `COMBO_WINDOW`, 6: ticks a direction history survives without a new direction press
- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `tick` in 1: one-`clk` enable pulse at 8 Hz; all game-state updates occur only when it is high
- `btn_left`, `btn_right`, `btn_up`, `btn_down`, `btn_attack` in 1 each: debounced levels
- `hit` in 1: one-`clk` pulse from collision logic
- `facing_right` in 1: current facing, used for knockback direction
- `character_state` out 3: 000 NORMAL, 001 PUNCH, 010 SPECIAL, 100 INJURED
- `move_state` out 2: 00 still, 01 forward (right), 10 backward (left)
- `in_air` out 1: jump in progress
- `x`, `y` out 7 each: sprite centre position

## Operation
- **Button edges:** previous levels are registered every `clk` (reset 0); press = level & ~prev.
- **`atk_req`:** sticky; set on an attack press; cleared when consumed or on reset. Holds at most one buffered attack.
- **`hit_pend`:** sticky; set on `hit`; cleared at the next tick in every state.
- **Combo history:** 3 entries of 2-bit direction codes (L=01, D=10, R=11, empty=00).
  - A left/down/right press shifts in its code and reloads the combo timer to `COMBO_WINDOW`.
  - Each tick decrements a nonzero timer. When the timer reaches 0, the history is cleared.
  - Match means history equals L,D,R, oldest to newest.
  - A press edge and a tick in the same `clk`: the press wins (reload, not decrement).
- **FSM (evaluated on `tick`):**
  - NORMAL:
    - `hit_pend` → INJURED, cnt=`INJ_TICKS`-1, `atk_req` cleared.
    - Else `atk_req` with match → SPECIAL, cnt=`SP_TICKS`-1, history cleared.
    - Else `atk_req` → PUNCH, cnt=`PUNCH_TICKS`-1.
    - Else walk:
      - right only: `move_state`=01, x=min(x+`STEP`, `X_MAX`)
      - left only: 10, x=max(x-`STEP`, `X_MIN`)
      - none or both: 00
    - `btn_up` held and `in_air`=0 → start jump (same tick as walk).
  - PUNCH/SPECIAL:
    - `hit_pend` → INJURED (hit beats completion).
    - Else cnt==0 → NORMAL; else cnt--.
    - `atk_req` stays buffered for NORMAL.
  - INJURED:
    - x moves `STEP` away from facing (right-facing moves left), clamped.
    - cnt==0 → NORMAL; else cnt--.
    - Hits are ignored; `hit_pend` is cleared.
  - `move_state`=00 whenever the next state is not NORMAL.
- **Jump:** jcnt counts 0..2·`JUMP_TICKS`-1.
  - First half: y-=`STEP`. Second half: y+=`STEP`.
  - At the end: y=`Y_GROUND`, `in_air`=0.
  - The jump continues independently of FSM state.
- **Arithmetic:** clamping uses 8-bit intermediates, so no 7-bit wrap.
- **Reset:** `character_state`=000, `move_state`=00, `in_air`=0, x=`X_INIT`, y=`Y_GROUND`. All counters, history, `atk_req`, `hit_pend` and previous levels are 0. Reset mid-jump or mid-attack aborts immediately.

## Timing
- All outputs are registered and update on the `clk` edge where `tick`=1.
- Latency: button press to state change is the next tick (≤125 ms + 1 `clk`).
- PUNCH is visible for exactly `PUNCH_TICKS` ticks; SPECIAL for `SP_TICKS`; INJURED for `INJ_TICKS`.
- `hit` and an attack in the same tick interval → INJURED; the attack is discarded.
- `rst` overrides `tick`.

## Structure
- Package `fighter_pkg`: state encodings (STATE_NORMAL/PUNCH/SP_0/INJURED), move encodings, direction codes. These are shared with the sprite renderer.
- Sub-module `combo_detector`: press edges, history, window timer, `match` output and clear input.

## Test plan
- Reset, then `btn_right` held 5 ticks → x 20→30, `move_state`=01; at `X_MAX` x stays 88.
- Attack press between ticks → next tick `character_state`=001 for 2 ticks, then 000.
- Presses L, D, R, then attack within 6 ticks → 010 for 4 ticks. Same sequence with a 7-tick gap before attack → 001.
- `hit` during PUNCH with `facing_right`=1, x=50 → 100 for 3 ticks, x 50→44, `move_state`=00; a second `hit` during INJURED has no effect.
- `btn_up` at ground → `in_air`=1, y 32→24 over 4 ticks, back to 32 after 8 ticks, `in_air`=0. Assert `rst` at tick 3 → y=32, `in_air`=0 next `clk`.

Source files
------------

// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - shared constants and encodings for the fighter action sequencer
// Encodings here are also consumed by the sprite renderer; keep them stable.
package fighter_pkg;

  localparam logic [6:0] X_INIT   = 7'd20;
  localparam logic [6:0] X_MIN    = 7'd8;
  localparam logic [6:0] X_MAX    = 7'd88;
  localparam logic [6:0] Y_GROUND = 7'd32;
  localparam logic [6:0] STEP     = 7'd2;

  localparam int PUNCH_TICKS  = 2;
  localparam int SP_TICKS     = 4;
  localparam int INJ_TICKS    = 3;
  localparam int JUMP_TICKS   = 4;
  localparam int COMBO_WINDOW = 6;

  typedef enum logic [2:0] {
    STATE_NORMAL  = 3'b000,
    STATE_PUNCH   = 3'b001,
    STATE_SP_0    = 3'b010,
    STATE_INJURED = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    MOVE_STILL = 2'b00,
    MOVE_FWD   = 2'b01,
    MOVE_BACK  = 2'b10
  } move_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_L    = 2'b01,
    DIR_D    = 2'b10,
    DIR_R    = 2'b11
  } dir_t;

  // Special move: left, down, right (oldest in the top bits)
  localparam logic [5:0] COMBO_SEQ = 6'b01_10_11;

endpackage

// File: rtl/fighter_action_ctrl_if.sv
// rtl/fighter_action_ctrl_if.sv - player input and sprite-state bundle
// Inputs : btn_left/right/up/down/attack (debounced levels), hit (1-clk pulse), facing_right
// Outputs: character_state[2:0], move_state[1:0], in_air, x[6:0], y[6:0]
// master = input/collision side and renderer view; slave = fighter_action_ctrl
interface fighter_action_ctrl_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       btn_attack;
  logic       hit;
  logic       facing_right;
  logic [2:0] character_state;
  logic [1:0] move_state;
  logic       in_air;
  logic [6:0] x;
  logic [6:0] y;

  modport master (
    output btn_left, btn_right, btn_up, btn_down, btn_attack, hit, facing_right,
    input  character_state, move_state, in_air, x, y
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down, btn_attack, hit, facing_right,
    output character_state, move_state, in_air, x, y
  );
endinterface

// File: rtl/combo_detector.sv
// rtl/combo_detector.sv - direction press history and special-move match
// Ports: clk, rst (sync, active-high), tick (8 Hz enable),
//        btn_left/btn_down/btn_right (levels), clear (drop history), match (history == L,D,R)
module combo_detector
  import fighter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_left,
  input  logic btn_down,
  input  logic btn_right,
  input  logic clear,
  output logic match
);

  logic       prev_l, prev_d, prev_r;
  logic [5:0] hist;
  logic [2:0] timer;
  dir_t       press_code;

  // Only one code enters per clk; simultaneous presses resolve left > down > right.
  always_comb begin
    press_code = DIR_NONE;
    if (btn_left & ~prev_l)       press_code = DIR_L;
    else if (btn_down & ~prev_d)  press_code = DIR_D;
    else if (btn_right & ~prev_r) press_code = DIR_R;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_l <= 1'b0;
      prev_d <= 1'b0;
      prev_r <= 1'b0;
      hist   <= 6'd0;
      timer  <= 3'd0;
    end else begin
      prev_l <= btn_left;
      prev_d <= btn_down;
      prev_r <= btn_right;
      // A press beats a tick in the same clk: reload instead of decrement.
      if (press_code != DIR_NONE) begin
        hist  <= {(clear ? 4'd0 : hist[3:0]), press_code};
        timer <= 3'(COMBO_WINDOW);
      end else if (clear) begin
        hist  <= 6'd0;
        timer <= 3'd0;
      end else if (tick && timer != 3'd0) begin
        timer <= timer - 3'd1;
        if (timer == 3'd1) hist <= 6'd0;
      end
    end
  end

  assign match = (hist == COMBO_SEQ);

endmodule

// File: rtl/fighter_action_ctrl.sv
// rtl/fighter_action_ctrl.sv - per-player action sequencer feeding the sprite renderer
// Ports: clk, rst (sync, active-high), tick (8 Hz enable pulse),
//        bus (slave): buttons, hit, facing_right in; character_state, move_state, in_air, x, y out
module fighter_action_ctrl
  import fighter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  fighter_action_ctrl_if.slave  bus
);

  state_t     state, state_nxt;
  move_t      move_q, move_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [2:0] jcnt, jcnt_nxt;
  logic [6:0] x_q, x_nxt, y_q, y_nxt;
  logic       in_air_q, in_air_nxt;
  logic       atk_req, atk_nxt, hit_pend, hit_nxt;
  logic       prev_atk, atk_press;
  logic       match, combo_clear, jump_start;
  logic [7:0] x_up;
  logic [6:0] x_right, x_left;

  combo_detector u_combo (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn_left  (bus.btn_left),
    .btn_down  (bus.btn_down),
    .btn_right (bus.btn_right),
    .clear     (combo_clear),
    .match     (match)
  );

  assign atk_press = bus.btn_attack & ~prev_atk;

  // 8-bit intermediates keep the clamp free of 7-bit wraparound.
  assign x_up    = {1'b0, x_q} + {1'b0, STEP};
  assign x_right = (x_up > {1'b0, X_MAX}) ? X_MAX : x_up[6:0];
  assign x_left  = ({1'b0, x_q} < ({1'b0, X_MIN} + {1'b0, STEP})) ? X_MIN : (x_q - STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= STATE_NORMAL;
      move_q   <= MOVE_STILL;
      cnt      <= 2'd0;
      jcnt     <= 3'd0;
      x_q      <= X_INIT;
      y_q      <= Y_GROUND;
      in_air_q <= 1'b0;
      atk_req  <= 1'b0;
      hit_pend <= 1'b0;
      prev_atk <= 1'b0;
    end else begin
      state    <= state_nxt;
      move_q   <= move_nxt;
      cnt      <= cnt_nxt;
      jcnt     <= jcnt_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      in_air_q <= in_air_nxt;
      atk_req  <= atk_nxt;
      hit_pend <= hit_nxt;
      prev_atk <= bus.btn_attack;
    end
  end

  always_comb begin
    state_nxt   = state;
    move_nxt    = move_q;
    cnt_nxt     = cnt;
    jcnt_nxt    = jcnt;
    x_nxt       = x_q;
    y_nxt       = y_q;
    in_air_nxt  = in_air_q;
    atk_nxt     = atk_req | atk_press;
    hit_nxt     = hit_pend | bus.hit;
    combo_clear = 1'b0;
    jump_start  = 1'b0;

    if (tick) begin
      // A hit arriving on the tick clk itself counts toward the next interval.
      hit_nxt  = bus.hit;
      move_nxt = MOVE_STILL;
      case (state)
        STATE_NORMAL: begin
          if (hit_pend) begin
            state_nxt = STATE_INJURED;
            cnt_nxt   = 2'(INJ_TICKS - 1);
            atk_nxt   = atk_press;
          end else if (atk_req && match) begin
            state_nxt   = STATE_SP_0;
            cnt_nxt     = 2'(SP_TICKS - 1);
            atk_nxt     = atk_press;
            combo_clear = 1'b1;
          end else if (atk_req) begin
            state_nxt = STATE_PUNCH;
            cnt_nxt   = 2'(PUNCH_TICKS - 1);
            atk_nxt   = atk_press;
          end else begin
            if (bus.btn_right && !bus.btn_left) begin
              move_nxt = MOVE_FWD;
              x_nxt    = x_right;
            end else if (bus.btn_left && !bus.btn_right) begin
              move_nxt = MOVE_BACK;
              x_nxt    = x_left;
            end
            jump_start = bus.btn_up && !in_air_q;
          end
        end
        STATE_PUNCH, STATE_SP_0: begin
          if (hit_pend) begin
            state_nxt = STATE_INJURED;
            cnt_nxt   = 2'(INJ_TICKS - 1);
          end else if (cnt == 2'd0) begin
            state_nxt = STATE_NORMAL;
          end else begin
            cnt_nxt = cnt - 2'd1;
          end
        end
        STATE_INJURED: begin
          // Knockback pushes away from the direction being faced.
          x_nxt = bus.facing_right ? x_left : x_right;
          if (cnt == 2'd0) state_nxt = STATE_NORMAL;
          else             cnt_nxt   = cnt - 2'd1;
        end
        default: state_nxt = STATE_NORMAL;
      endcase

      // Jump runs on its own counter regardless of the action state.
      if (in_air_q || jump_start) begin
        in_air_nxt = 1'b1;
        if (jcnt < 3'(JUMP_TICKS)) y_nxt = y_q - STEP;
        else                       y_nxt = y_q + STEP;
        if (jcnt == 3'(2 * JUMP_TICKS - 1)) begin
          y_nxt      = Y_GROUND;
          in_air_nxt = 1'b0;
          jcnt_nxt   = 3'd0;
        end else begin
          jcnt_nxt = jcnt + 3'd1;
        end
      end
    end
  end

  assign bus.character_state = state;
  assign bus.move_state      = move_q;
  assign bus.in_air          = in_air_q;
  assign bus.x               = x_q;
  assign bus.y               = y_q;

endmodule
